// File: rtl/ysyx_23060096_wbu_pkg.sv
// Shared constants and types for the write-back unit and its scoreboard.
package ysyx_23060096_wbu_pkg;

  localparam int WBU_ADDR_WIDTH = 5;
  localparam int WBU_DATA_WIDTH = 32;
  localparam int X0_IDX         = 0;

  localparam int                  CNT_WIDTH = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = 2'd0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 2'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = 2'd3;

  typedef enum logic {
    GRANT_EXU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Per-register pending-write counters: issue stall, source busy flags and
// detection of results that arrive for a register with nothing outstanding.
module ysyx_23060096_scoreboard
  import ysyx_23060096_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = WBU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  src_fire,
  input  logic [ADDR_WIDTH-1:0] src_rd,
  input  logic                  rf_wen,
  input  logic [ADDR_WIDTH-1:0] rf_waddr,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  err
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0_ADDR = ADDR_WIDTH'(X0_IDX);

  logic [CNT_WIDTH-1:0] cnt_r [NREG];
  logic                 skip_dec_r;
  logic                 err_r;
  logic [NREG-1:0]      inc_s;
  logic [NREG-1:0]      dec_s;
  logic                 dec_any_s;
  logic                 iss_fire_s;
  logic                 orphan_s;

  // Stall, busy and orphan-write decode; an orphan write's commit must not retire a counter.
  always_comb begin
    dec_any_s = rf_wen & ~skip_dec_r;
    iss_ready = 1'b1;
    if ((iss_rd != X0_ADDR) && (cnt_r[iss_rd] == CNT_MAX) &&
        !(dec_any_s && (rf_waddr == iss_rd))) begin
      iss_ready = 1'b0;
    end else begin
      iss_ready = 1'b1;
    end
    iss_fire_s = iss_valid & iss_ready;
    inc_s = {NREG{1'b0}};
    dec_s = {NREG{1'b0}};
    for (int r = X0_IDX + 1; r < NREG; r++) begin
      inc_s[r] = iss_fire_s & (iss_rd == ADDR_WIDTH'(r));
      dec_s[r] = dec_any_s & (rf_waddr == ADDR_WIDTH'(r));
    end
    busy_rs1 = (q_rs1 != X0_ADDR) && (cnt_r[q_rs1] != CNT_ZERO);
    busy_rs2 = (q_rs2 != X0_ADDR) && (cnt_r[q_rs2] != CNT_ZERO);
    orphan_s = src_fire && (src_rd != X0_ADDR) && (cnt_r[src_rd] == CNT_ZERO) &&
               !(iss_fire_s && (iss_rd == src_rd));
  end

  // Counter array update with saturation guards, plus sticky error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      skip_dec_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      for (int r = X0_IDX + 1; r < NREG; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10: begin
            if (cnt_r[r] != CNT_MAX) cnt_r[r] <= cnt_r[r] + CNT_ONE;
          end
          2'b01: begin
            if (cnt_r[r] != CNT_ZERO) cnt_r[r] <= cnt_r[r] - CNT_ONE;
          end
          default: cnt_r[r] <= cnt_r[r];
        endcase
      end
      skip_dec_r <= orphan_s;
      err_r      <= err_r | orphan_s;
    end
  end

  assign err = err_r;

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: round-robin arbiter between EXU and LSU results feeding a
// registered register-file write port, with a RAW hazard scoreboard.
module ysyx_23060096_wbu
  import ysyx_23060096_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
  parameter int DATA_WIDTH = WBU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  output logic                  err
);

  grant_e                last_grant_r;
  logic                  conflict_s;
  logic                  exu_fire_s;
  logic                  lsu_fire_s;
  logic                  src_fire_s;
  logic [ADDR_WIDTH-1:0] src_rd_s;
  logic [DATA_WIDTH-1:0] src_data_s;

  // Arbitration: a lone valid source wins; on conflict the source not granted last time wins.
  always_comb begin
    conflict_s = exu_valid & lsu_valid;
    exu_ready  = exu_valid & (~lsu_valid | (last_grant_r == GRANT_LSU));
    lsu_ready  = lsu_valid & (~exu_valid | (last_grant_r == GRANT_EXU));
    exu_fire_s = exu_valid & exu_ready;
    lsu_fire_s = lsu_valid & lsu_ready;
    src_fire_s = exu_fire_s | lsu_fire_s;
    if (exu_fire_s) begin
      src_rd_s   = exu_rd;
      src_data_s = exu_data;
    end else begin
      src_rd_s   = lsu_rd;
      src_data_s = lsu_data;
    end
  end

  // Grant pointer and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= GRANT_EXU;
      rf_wen       <= 1'b0;
      rf_waddr     <= {ADDR_WIDTH{1'b0}};
      rf_wdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      if (conflict_s) begin
        last_grant_r <= lsu_fire_s ? GRANT_LSU : GRANT_EXU;
      end
      if (src_fire_s) begin
        rf_waddr <= src_rd_s;
        rf_wdata <= src_data_s;
        rf_wen   <= (src_rd_s != ADDR_WIDTH'(X0_IDX));
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

  ysyx_23060096_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .src_fire (src_fire_s),
    .src_rd   (src_rd_s),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .err      (err)
  );

endmodule
